ml_conv_engine_mc: RTL and testbench



---
 rtl/ml_acc_pkg.sv | 34 +++
 rtl/ml_conv_engine_mc_if.sv | 21 ++
 rtl/ml_mac_pipe.sv | 38 +++
 rtl/ml_conv_engine_mc.sv | 148 ++++++++++++++
 tb/tb_ml_conv_engine_mc.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/ml_acc_pkg.sv
// Shared constants, FSM state codes and the saturation helper for the ml_acc engines.
package ml_acc_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CHECK = 3'd1;
  localparam state_t ST_READ  = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_WRITE = 3'd4;
  localparam state_t ST_FIN   = 3'd5;

  localparam logic [15:0] STATUS_MAGIC = 16'hD00D;
  localparam int BRAM_RD_LAT = 1;
  // Product register plus the BRAM return stage must both empty before WRITE.
  localparam int DRAIN_CYC   = BRAM_RD_LAT + 1;
  localparam int SAT_W       = 128;

  // Clamp a signed value into the range of a w-bit signed number.
  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                       input int unsigned w);
    logic [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    one    = '0;
    one[0] = 1'b1;
    hi     = (one << (w - 1)) - one;
    lo     = ~hi;
    if (v > hi)      saturate = hi;
    else if (v < lo) saturate = lo;
    else             saturate = v;
  endfunction

endpackage

// File: rtl/ml_conv_engine_mc_if.sv
// BRAM-side bus of the conv engine: weight/input read ports and the OutAct write port.
interface ml_conv_engine_mc_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] w_addr;
  logic              w_en;
  logic [DATA_W-1:0] w_dout;
  logic [ADDR_W-1:0] x_addr;
  logic              x_en;
  logic [DATA_W-1:0] x_dout;
  logic [ADDR_W-1:0] o_addr;
  logic              o_we;
  logic [DATA_W-1:0] o_din;

  // No backpressure: reads return data one cycle after *_en, writes land on the o_we cycle.
  modport master (output w_addr, w_en, x_addr, x_en, o_addr, o_we, o_din,
                  input  w_dout, x_dout);
  modport slave  (input  w_addr, w_en, x_addr, x_en, o_addr, o_we, o_din,
                  output w_dout, x_dout);
endinterface

// File: rtl/ml_mac_pipe.sv
// Multiply stage and accumulator of the conv engine; clear has priority over accumulate.
module ml_mac_pipe #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 70
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] a_x;
  logic signed [2*DATA_W-1:0] b_x;
  logic signed [2*DATA_W-1:0] prod;
  logic                       prod_vld;

  always_comb begin
    a_x = {{DATA_W{a[DATA_W-1]}}, a};
    b_x = {{DATA_W{b[DATA_W-1]}}, b};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
    end else begin
      prod_vld <= in_valid;
      if (in_valid) prod <= a_x * b_x;
      if (clear)         acc <= '0;
      else if (prod_vld) acc <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end
  end

endmodule

// File: rtl/ml_conv_engine_mc.sv
// Multi-channel dot-product engine: per channel, stream len taps through the MAC,
// then shift/saturate/ReLU the accumulator into one OutAct word.
module ml_conv_engine_mc
  import ml_acc_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MAX_LEN = 64,
  parameter int MAX_CH  = 16,
  parameter int ADDR_W  = 12,
  parameter int ACC_W   = 2*DATA_W + $clog2(MAX_LEN),
  parameter int LEN_W   = $clog2(MAX_LEN+1),
  parameter int CH_W    = $clog2(MAX_CH+1)
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [CH_W-1:0]  cfg_num_ch,
  input  logic [5:0]       cfg_shift,
  input  logic             cfg_relu,
  ml_conv_engine_mc_if.master bram,
  output logic             busy,
  output logic             done,
  output logic [31:0]      status,
  output state_t           dbg_state
);

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [CH_W-1:0]   nch_q;
  logic [5:0]        shift_q;
  logic              relu_q;
  logic [LEN_W-1:0]  k;
  logic [CH_W-1:0]   ch;
  logic [ADDR_W-1:0] base;
  logic              cfg_err;
  logic              done_sticky;
  logic              rd_vld;
  logic              cfg_bad;

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [SAT_W-1:0]  sat;
  logic        [DATA_W-1:0] result;

  assign cfg_bad = (len_q == '0) || (32'(len_q) > MAX_LEN) ||
                   (nch_q == '0) || (32'(nch_q) > MAX_CH);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state       <= ST_IDLE;
      len_q       <= '0;
      nch_q       <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      k           <= '0;
      ch          <= '0;
      base        <= '0;
      cfg_err     <= 1'b0;
      done_sticky <= 1'b0;
      rd_vld      <= 1'b0;
    end else begin
      rd_vld <= (state == ST_READ);
      case (state)
        ST_IDLE: if (start) begin
          len_q   <= cfg_len;
          nch_q   <= cfg_num_ch;
          shift_q <= cfg_shift;
          relu_q  <= cfg_relu;
          state   <= ST_CHECK;
        end
        ST_CHECK: begin
          k    <= '0;
          ch   <= '0;
          base <= '0;
          if (cfg_bad) begin
            cfg_err <= 1'b1;
            state   <= ST_FIN;
          end else begin
            cfg_err     <= 1'b0;
            done_sticky <= 1'b0;
            state       <= ST_READ;
          end
        end
        ST_READ: begin
          if (k == len_q - LEN_W'(1)) begin
            k     <= '0;
            state <= ST_DRAIN;
          end else begin
            k <= k + LEN_W'(1);
          end
        end
        // k doubles as the drain cycle counter.
        ST_DRAIN: begin
          if (k == LEN_W'(DRAIN_CYC-1)) begin
            k     <= '0;
            state <= ST_WRITE;
          end else begin
            k <= k + LEN_W'(1);
          end
        end
        ST_WRITE: begin
          ch    <= ch + CH_W'(1);
          base  <= base + ADDR_W'(len_q);
          state <= ((ch + CH_W'(1)) < nch_q) ? ST_READ : ST_FIN;
        end
        ST_FIN: begin
          done_sticky <= 1'b1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ml_mac_pipe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk      (ACLK),
    .rst      (ARESET),
    .clear    ((state == ST_READ) && (k == '0)),
    .in_valid (rd_vld),
    .a        (bram.x_dout),
    .b        (bram.w_dout),
    .acc      (acc)
  );

  always_comb begin
    shifted = acc >>> shift_q;
    sat     = saturate({{(SAT_W-ACC_W){shifted[ACC_W-1]}}, shifted}, DATA_W);
    result  = sat[DATA_W-1:0];
    if (relu_q && result[DATA_W-1]) result = '0;
  end

  always_comb begin
    bram.x_en   = (state == ST_READ);
    bram.w_en   = (state == ST_READ);
    bram.x_addr = bram.x_en ? ADDR_W'(k) : '0;
    bram.w_addr = bram.w_en ? base + ADDR_W'(k) : '0;
    bram.o_we   = (state == ST_WRITE);
    bram.o_addr = bram.o_we ? ADDR_W'(ch) : '0;
    bram.o_din  = bram.o_we ? result : '0;
  end

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FIN);
  assign status    = {STATUS_MAGIC, 8'(ch), 5'b0, cfg_err, done_sticky, busy};
  assign dbg_state = state;

endmodule

// File: tb/tb_ml_conv_engine_mc.sv
// Directed bench for ml_conv_engine_mc: BRAM models, arithmetic reference model, write scoreboard.
module tb_ml_conv_engine_mc;
  import ml_acc_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;
  localparam int W      = ADDR_W + DATA_W;

  logic        tb_ACLK = 1'b0;
  logic        tb_ARESET;
  logic        start;
  logic [6:0]  cfg_len;
  logic [4:0]  cfg_num_ch;
  logic [5:0]  cfg_shift;
  logic        cfg_relu;
  logic        busy;
  logic        done;
  logic [31:0] status;
  state_t      dbg_state;

  ml_conv_engine_mc_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ml_conv_engine_mc dut (
    .ACLK       (tb_ACLK),
    .ARESET     (tb_ARESET),
    .start      (start),
    .cfg_len    (cfg_len),
    .cfg_num_ch (cfg_num_ch),
    .cfg_shift  (cfg_shift),
    .cfg_relu   (cfg_relu),
    .bram       (bus),
    .busy       (busy),
    .done       (done),
    .status     (status),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 tb_ACLK = ~tb_ACLK;

  // ---------------- BRAM models ----------------
  logic [DATA_W-1:0] wmem [0:4095];
  logic [DATA_W-1:0] xmem [0:4095];
  logic [DATA_W-1:0] omem [0:4095];

  always @(posedge tb_ACLK) begin
    if (bus.x_en) bus.x_dout <= xmem[bus.x_addr];
    if (bus.w_en) bus.w_dout <= wmem[bus.w_addr];
    if (bus.o_we) omem[bus.o_addr] <= bus.o_din;
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int we_cnt, en_cnt, done_cnt, last_lat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge tb_ACLK) begin
    logic [W-1:0] e;
    if (bus.x_en) en_cnt++;
    if (done) done_cnt++;
    if (bus.o_we) begin
      we_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write actual=0x%0h required=none", {bus.o_addr, bus.o_din});
      end else begin
        e = exp_q.pop_front();
        chk("owrite", {bus.o_addr, bus.o_din}, e);
      end
    end
  end

  // Reference: exact dot product, arithmetic shift, clamp to 32-bit signed, optional ReLU.
  function automatic logic [DATA_W-1:0] model_out(input int len, input int c, input int sh,
                                                  input bit relu);
    logic signed [127:0] s;
    logic signed [127:0] maxv;
    logic signed [127:0] minv;
    maxv = 128'sh7FFF_FFFF;
    minv = -128'sh8000_0000;
    s = '0;
    for (int i = 0; i < len; i++)
      s = s + $signed(xmem[i]) * $signed(wmem[c*len + i]);
    s = s >>> sh;
    if (s > maxv) s = maxv;
    if (s < minv) s = minv;
    if (relu && s < 0) s = '0;
    return s[DATA_W-1:0];
  endfunction

  // ---------------- driver ----------------
  task automatic run(input int len, input int nch, input int sh, input bit relu,
                     input int glitch_cyc);
    int  cyc;
    int  lat_exp;
    bit  valid;
    valid   = (len >= 1) && (len <= 64) && (nch >= 1) && (nch <= 16);
    lat_exp = valid ? 2 + nch*(len + 3) : 2;
    if (valid)
      for (int c = 0; c < nch; c++) exp_q.push_back({12'(c), model_out(len, c, sh, relu)});
    for (int i = 0; i < 32; i++) omem[i] = 32'hDEAD_BEEF;
    we_cnt = 0; en_cnt = 0; done_cnt = 0;
    cfg_len = 7'(len); cfg_num_ch = 5'(nch); cfg_shift = 6'(sh); cfg_relu = relu;
    start = 1'b1;
    cyc = 0;
    do begin
      @(negedge tb_ACLK);
      cyc++;
      start = 1'b0;
      if (cyc == glitch_cyc) begin
        start = 1'b1; cfg_len = 7'd1; cfg_num_ch = 5'd1; cfg_shift = 6'd9;
      end
    end while (!done && cyc < 5000);
    last_lat = cyc;
    chk("latency", cyc, lat_exp);
    @(negedge tb_ACLK);
    chk("queue_empty", exp_q.size(), 0);
    chk("write_count", we_cnt, valid ? nch : 0);
    chk("read_count", en_cnt, valid ? nch*len : 0);
    chk("done_pulses", done_cnt, 1);
    chk("busy_after", busy, 0);
    exp_q.delete();
  endtask

  task automatic load_ramp(input int ch1_weight);
    for (int i = 0; i < 64; i++) begin
      xmem[i] = 32'(i);
      wmem[i] = (i < 25) ? 32'd1 : 32'(ch1_weight);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 4096; i++) begin wmem[i] = '0; xmem[i] = '0; omem[i] = '0; end
    bus.x_dout = '0; bus.w_dout = '0;
    tb_ARESET = 1'b1; start = 1'b0;
    cfg_len = '0; cfg_num_ch = '0; cfg_shift = '0; cfg_relu = 1'b0;
    repeat (3) @(negedge tb_ACLK);
    chk("rst_status", status, 32'hD00D_0000);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bram_en", {bus.x_en, bus.w_en, bus.o_we}, 0);
    tb_ARESET = 1'b0;
    @(negedge tb_ACLK);

    // basic single channel
    load_ramp(2);
    run(25, 1, 0, 0, 0);
    chk("basic_lat", last_lat, 30);
    chk("basic_out", omem[0], 300);
    chk("basic_status", status, 32'hD00D_0102);

    // two channels, then start pulses mid-run with a different config
    run(25, 2, 0, 0, 0);
    chk("multi_out0", omem[0], 300);
    chk("multi_out1", omem[1], 600);
    run(25, 2, 0, 0, 10);
    chk("glitch_out1", omem[1], 600);

    // sign and ReLU
    for (int i = 0; i < 25; i++) wmem[i] = 32'hFFFF_FFFF;
    run(25, 1, 0, 0, 0);
    chk("neg_out", omem[0], 32'hFFFF_FED4);
    run(25, 1, 0, 1, 0);
    chk("relu_out", omem[0], 32'h0);

    // saturation and shift
    for (int i = 0; i < 4; i++) begin xmem[i] = 32'h7FFF_FFFF; wmem[i] = 32'h7FFF_FFFF; end
    run(4, 1, 0, 0, 0);
    chk("sat_pos", omem[0], 32'h7FFF_FFFF);
    for (int i = 0; i < 4; i++) wmem[i] = 32'h8000_0000;
    run(4, 1, 0, 0, 0);
    chk("sat_neg", omem[0], 32'h8000_0000);
    for (int i = 0; i < 4; i++) begin xmem[i] = 32'd4; wmem[i] = 32'd4; end
    run(4, 1, 2, 0, 0);
    chk("shift_out", omem[0], 16);

    // bad configs, then a good one clears cfg_err
    run(0, 1, 0, 0, 0);
    chk("err_status", status, 32'hD00D_0006);
    run(65, 1, 0, 0, 0);
    run(4, 0, 0, 0, 0);
    run(4, 17, 0, 0, 0);
    chk("err_status2", status, 32'hD00D_0006);
    run(4, 1, 2, 0, 0);
    chk("err_cleared", status, 32'hD00D_0102);

    // len=1 across every channel
    xmem[0] = 32'd3;
    for (int c = 0; c < 16; c++) wmem[c] = 32'(c + 1);
    run(1, 16, 0, 0, 0);
    chk("maxch_out0", omem[0], 3);
    chk("maxch_out15", omem[15], 48);
    chk("maxch_status", status, 32'hD00D_1002);

    // reset during READ of channel 0
    load_ramp(2);
    we_cnt = 0; done_cnt = 0;
    cfg_len = 7'd25; cfg_num_ch = 5'd2; cfg_shift = 6'd0; cfg_relu = 1'b0;
    start = 1'b1;
    @(negedge tb_ACLK);
    start = 1'b0;
    repeat (4) @(negedge tb_ACLK);
    chk("pre_abort_busy", busy, 1);
    tb_ARESET = 1'b1;
    @(negedge tb_ACLK);
    chk("abort_status", status, 32'hD00D_0000);
    chk("abort_outs", {busy, done, bus.o_we, bus.x_en, bus.w_en, bus.x_addr, bus.w_addr}, 0);
    repeat (2) @(negedge tb_ACLK);
    tb_ARESET = 1'b0;
    repeat (40) @(negedge tb_ACLK);
    chk("abort_no_write", we_cnt, 0);
    chk("abort_no_done", done_cnt, 0);
    run(25, 2, 0, 0, 0);
    chk("post_abort_out0", omem[0], 300);
    chk("post_abort_out1", omem[1], 600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
